// File: rtl/beef_pkg.sv
// Shared opcode encodings and sequencer state type for the BeeF core.
package beef_pkg;

  // 9-bit instruction codes; brackets use their ASCII values.
  localparam logic [8:0] OP_NOP   = 9'h000;
  localparam logic [8:0] OP_OPEN  = 9'h05B;
  localparam logic [8:0] OP_CLOSE = 9'h05D;
  localparam logic [8:0] OP_HALT  = 9'h100;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SEARCH = 2'd1,
    HALT   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_loop_stack.sv
// Loop-address LIFO: holds the pc of each taken '[' until its ']' falls through.
// Top of stack is a combinational read of registered storage.
module loop_stack #(
  parameter int STACK_DEPTH = 16,
  parameter int PC_W        = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] mem [0:STACK_DEPTH-1];
  logic [AW:0]     sp;
  logic [AW-1:0]   top_idx;

  assign empty   = (sp == '0);
  assign full    = (sp == (AW+1)'(STACK_DEPTH));
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];

  // Stack pointer: the only control state in the stack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (AW+1)'(1);
    end
  end

  // Entry storage: written on push, never cleared.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer for the BeeF core: pc generation, forward
// bracket search, backward jumps through the loop stack, halt and fault.
module pc_sequencer
  import beef_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [8:0]      scan_instruction,
  input  logic            cell_zero,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic            searching,
  output logic            delay,
  output logic            delayed_op,
  output logic            halted,
  output logic            fault
);

  localparam logic [PC_W-1:0]    PC_MAX    = {PC_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               searching_q, searching_d;
  logic               delay_q, delay_d;
  logic               delayed_op_q, delayed_op_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  logic               push, pop;
  logic [PC_W-1:0]    top;
  logic               empty, full;

  loop_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .PC_W        (PC_W)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (pc_q),
    .top     (top),
    .empty   (empty),
    .full    (full)
  );

  assign pc_inc = pc_q + PC_W'(1);

  // State register: everything holds while stalled because the next-state
  // logic returns current values when stall is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      pc_q         <= '0;
      depth_q      <= '0;
      searching_q  <= 1'b0;
      delay_q      <= 1'b0;
      delayed_op_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      depth_q      <= depth_d;
      searching_q  <= searching_d;
      delay_q      <= delay_d;
      delayed_op_q <= delayed_op_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state decode of the instruction at pc for each sequencer state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    depth_d      = depth_q;
    searching_d  = searching_q;
    delay_d      = 1'b0;
    delayed_op_d = delayed_op_q;
    halted_d     = halted_q;
    fault_d      = fault_q;
    push         = 1'b0;
    pop          = 1'b0;

    if (!stall) begin
      case (state_q)
        RUN: begin
          if (scan_instruction == OP_OPEN) begin
            if (cell_zero) begin
              depth_d     = DEPTH_W'(1);
              searching_d = 1'b1;
              state_d     = SEARCH;
              pc_d        = pc_inc;
            end else if (full) begin
              fault_d  = 1'b1;
              halted_d = 1'b1;
              state_d  = HALT;
            end else begin
              push = 1'b1;
              pc_d = pc_inc;
            end
          end else if (scan_instruction == OP_CLOSE) begin
            if (empty) begin
              fault_d  = 1'b1;
              halted_d = 1'b1;
              state_d  = HALT;
            end else if (!cell_zero) begin
              // Jump back to the instruction after the matching '['; the
              // entry stays stacked for the next iteration.
              pc_d         = top + PC_W'(1);
              delay_d      = 1'b1;
              delayed_op_d = 1'b1;
            end else begin
              pop  = 1'b1;
              pc_d = pc_inc;
            end
          end else if (scan_instruction == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d = pc_inc;
          end
        end

        SEARCH: begin
          pc_d = pc_inc;
          if (scan_instruction == OP_CLOSE && depth_q == DEPTH_W'(1)) begin
            searching_d  = 1'b0;
            depth_d      = '0;
            delay_d      = 1'b1;
            delayed_op_d = 1'b0;
            state_d      = RUN;
          end else if ((scan_instruction == OP_OPEN && depth_q == DEPTH_MAX) ||
                       pc_q == PC_MAX) begin
            // Nesting overflow or no match before the end of memory.
            pc_d        = pc_q;
            searching_d = 1'b0;
            fault_d     = 1'b1;
            halted_d    = 1'b1;
            state_d     = HALT;
          end else if (scan_instruction == OP_OPEN) begin
            depth_d = depth_q + DEPTH_W'(1);
          end else if (scan_instruction == OP_CLOSE) begin
            depth_d = depth_q - DEPTH_W'(1);
          end
        end

        HALT: begin
          searching_d = 1'b0;
        end

        default: begin
          searching_d = 1'b0;
          fault_d     = 1'b1;
          halted_d    = 1'b1;
          state_d     = HALT;
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign searching  = searching_q;
  assign delay      = delay_q & ~stall;
  assign delayed_op = delayed_op_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a scoreboard of expected output sets.
module tb_pc_sequencer;
  import beef_pkg::*;

  localparam int PC_W = 16;
  localparam int OW   = PC_W + 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [8:0]      scan_instruction;
  logic            cell_zero = 1'b0;
  logic            stall = 1'b0;
  logic [PC_W-1:0] pc;
  logic            searching, delay, delayed_op, halted, fault;

  logic [8:0] imem [0:255];

  typedef struct {
    string         tag;
    logic [OW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  assign scan_instruction = imem[pc[7:0]];

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (16),
    .DEPTH_W     (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .scan_instruction (scan_instruction),
    .cell_zero        (cell_zero),
    .stall            (stall),
    .pc               (pc),
    .searching        (searching),
    .delay            (delay),
    .delayed_op       (delayed_op),
    .halted           (halted),
    .fault            (fault)
  );

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = OP_NOP;
  endtask

  task automatic push_exp(input string tag, input logic [PC_W-1:0] epc,
                          input bit es, input bit ed, input bit eo,
                          input bit eh, input bit ef);
    exp_t e;
    e.tag = tag;
    e.val = {epc, es, ed, eo, eh, ef};
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t          e;
    logic [OW-1:0] obs;
    e   = sb.pop_front();
    obs = {pc, searching, delay, delayed_op, halted, fault};
    checks++;
    assert (obs === e.val)
    else begin
      errors++;
      $error("FAIL %s: observed pc=%h s/d/op/h/f=%b required pc=%h s/d/op/h/f=%b",
             e.tag, obs[OW-1:5], obs[4:0], e.val[OW-1:5], e.val[4:0]);
    end
  endtask

  // One clock: drive inputs, queue expectation, sample 1 time unit after the edge.
  task automatic step(input string tag, input bit cz, input bit st,
                      input logic [PC_W-1:0] epc, input bit es, input bit ed,
                      input bit eo, input bit eh, input bit ef);
    cell_zero = cz;
    stall     = st;
    push_exp(tag, epc, es, ed, eo, eh, ef);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic check_now(input string tag, input logic [PC_W-1:0] epc,
                           input bit es, input bit ed, input bit eo,
                           input bit eh, input bit ef);
    push_exp(tag, epc, es, ed, eo, eh, ef);
    #1;
    compare_out();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic do_reset();
    #2;
    reset_n   = 1'b0;
    stall     = 1'b0;
    cell_zero = 1'b0;
    check_now("reset_clear", 16'h0000, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    clear_mem();
    #2;
    check_now("reset_state", 16'h0000, 0, 0, 0, 0, 0);

    // "+[-]" then halt
    imem[1] = OP_OPEN;
    imem[3] = OP_CLOSE;
    imem[4] = OP_HALT;
    @(negedge clk);
    reset_n = 1'b1;
    step("loop_nop0",   0, 0, 16'd1, 0, 0, 0, 0, 0);
    step("loop_open",   0, 0, 16'd2, 0, 0, 0, 0, 0);
    step("loop_body1",  0, 0, 16'd3, 0, 0, 0, 0, 0);
    step("loop_jump1",  0, 0, 16'd2, 0, 1, 1, 0, 0);
    step("loop_body2",  0, 0, 16'd3, 0, 0, 1, 0, 0);
    step("loop_jump2",  0, 0, 16'd2, 0, 1, 1, 0, 0);
    step("loop_body3",  0, 0, 16'd3, 0, 0, 1, 0, 0);
    step("loop_exit",   1, 0, 16'd4, 0, 0, 1, 0, 0);
    step("loop_halt",   0, 0, 16'd4, 0, 0, 1, 1, 0);
    step("loop_halt_h", 0, 0, 16'd4, 0, 0, 1, 1, 0);

    // "[[+]+]" then halt, search taken at pc0
    do_reset();
    clear_mem();
    imem[0] = OP_OPEN;
    imem[1] = OP_OPEN;
    imem[3] = OP_CLOSE;
    imem[5] = OP_CLOSE;
    imem[6] = OP_HALT;
    reset_n = 1'b1;
    step("srch_enter", 1, 0, 16'd1, 1, 0, 0, 0, 0);
    step("srch_d2",    0, 0, 16'd2, 1, 0, 0, 0, 0);
    step("srch_p2",    1, 0, 16'd3, 1, 0, 0, 0, 0);
    step("srch_d1",    0, 0, 16'd4, 1, 0, 0, 0, 0);
    step("srch_p4",    1, 0, 16'd5, 1, 0, 0, 0, 0);
    step("srch_exit",  0, 0, 16'd6, 0, 1, 0, 0, 0);
    step("srch_halt",  0, 0, 16'd6, 0, 0, 0, 1, 0);

    // Same program, stalled three cycles at depth 2
    do_reset();
    reset_n = 1'b1;
    step("stl_enter", 1, 0, 16'd1, 1, 0, 0, 0, 0);
    step("stl_d2",    0, 0, 16'd2, 1, 0, 0, 0, 0);
    step("stl_hold1", 0, 1, 16'd2, 1, 0, 0, 0, 0);
    step("stl_hold2", 1, 1, 16'd2, 1, 0, 0, 0, 0);
    step("stl_hold3", 0, 1, 16'd2, 1, 0, 0, 0, 0);
    step("stl_p2",    0, 0, 16'd3, 1, 0, 0, 0, 0);
    step("stl_d1",    0, 0, 16'd4, 1, 0, 0, 0, 0);
    step("stl_p4",    0, 0, 16'd5, 1, 0, 0, 0, 0);
    step("stl_exit",  0, 0, 16'd6, 0, 1, 0, 0, 0);
    stall = 1'b1;
    check_now("stl_delay_mask", 16'd6, 0, 0, 0, 0, 0);
    step("stl_halt_held", 0, 1, 16'd6, 0, 0, 0, 0, 0);
    step("stl_halt",      0, 0, 16'd6, 0, 0, 0, 1, 0);

    // ']' with an empty stack
    do_reset();
    clear_mem();
    imem[1] = OP_CLOSE;
    reset_n = 1'b1;
    step("uf_nop",    0, 0, 16'd1, 0, 0, 0, 0, 0);
    step("uf_fault",  0, 0, 16'd1, 0, 0, 0, 1, 1);
    step("uf_frozen", 1, 0, 16'd1, 0, 0, 0, 1, 1);

    // 17 nested taken '[' against a 16-entry stack
    do_reset();
    clear_mem();
    for (int i = 0; i < 17; i++) imem[i] = OP_OPEN;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step("of_push_ok", 0, 0, 16'(i + 1), 0, 0, 0, 0, 0);
    end
    step("of_fault",  0, 0, 16'd16, 0, 0, 0, 1, 1);
    step("of_frozen", 0, 0, 16'd16, 0, 0, 0, 1, 1);

    // Asynchronous reset in the middle of a long search
    do_reset();
    clear_mem();
    imem[0] = OP_OPEN;
    reset_n = 1'b1;
    step("ar_enter", 1, 0, 16'd1, 1, 0, 0, 0, 0);
    for (int i = 2; i <= 64; i++) begin
      step("ar_search", 0, 0, 16'(i), 1, 0, 0, 0, 0);
    end
    #2;
    reset_n = 1'b0;
    check_now("ar_clear_async", 16'h0000, 0, 0, 0, 0, 0);
    imem[0] = OP_NOP;
    @(negedge clk);
    reset_n = 1'b1;
    check_now("ar_pc_at_release", 16'h0000, 0, 0, 0, 0, 0);
    step("ar_first_edge", 0, 0, 16'd1, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Drives the instruction-fetch side of the BeeF core: generates pc, searching and delay/delayed_op, and consumes fetched instructions.
- Resolves loop brackets. '[' with a zero cell runs a forward bracket search; ']' with a nonzero cell jumps back through a hardware loop-address stack.
- Sits between instruction memory (second, unmasked read port) and the fetch stage; it is the producer of every control input that fetch samples.

Parameters:
- PC_W, 16: program counter width.
- STACK_DEPTH, 16: loop-address stack entries.
- DEPTH_W, 8: forward-search nesting counter width.

Ports:
- clk  input  1  core clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- scan_instruction  input  9  unmasked instruction memory output at current pc
- cell_zero  input  1  current data cell == 0; valid in the same cycle as scan_instruction
- stall  input  1  hold all state, including pc
- pc  output  PC_W  instruction address
- searching  output  1  forward bracket search in progress (fetch outputs NOP)
- delay  output  1  one-cycle pulse on a pc redirect
- delayed_op  output  1  redirect type, valid with delay: 1 = backward jump, 0 = search exit
- halted  output  1  sequencer stopped
- fault  output  1  sticky error: stack over/underflow, depth overflow, search past end of memory

Behaviour:
- Reset (async, reset_n low): pc=0, searching=0, delay=0, delayed_op=0, halted=0, fault=0; stack pointer=0; depth=0; state=RUN. A reset mid-search or mid-jump aborts cleanly to these values.
- States: RUN, SEARCH, HALT. State changes only on posedge clk with stall=0.
- stall=1: pc, state, stack, depth and fault all hold. delay is forced to 0 during a stall.
- RUN, per cycle, decode of scan_instruction:
  - OP_OPEN with cell_zero=1: depth<=1, searching<=1, state<=SEARCH, pc<=pc+1. No stack push.
  - OP_OPEN with cell_zero=0: push pc onto the stack, pc<=pc+1. If the stack is full: fault<=1, state<=HALT.
  - OP_CLOSE with cell_zero=0: pc<=top+1; top is kept on the stack; delay<=1; delayed_op<=1. If the stack is empty: fault, HALT.
  - OP_CLOSE with cell_zero=1: pop, pc<=pc+1. If the stack is empty: fault, HALT.
  - OP_HALT: halted<=1, state<=HALT, pc holds.
  - Any other code: pc<=pc+1. pc wraps from all-ones to 0 without fault.
- SEARCH, per cycle, pc<=pc+1 with cell_zero ignored:
  - OP_OPEN: depth+1. If depth is already at maximum: fault, HALT.
  - OP_CLOSE with depth==1: searching<=0, depth<=0, delay<=1, delayed_op<=0, state<=RUN. pc<=pc+1, i.e. the instruction after the matching ']'.
  - OP_CLOSE with depth>1: depth-1.
  - OP_HALT: treated as a normal instruction and skipped.
  - pc at all-ones and no match: fault, HALT.
- HALT: all outputs hold except delay=0 and searching=0; halted=1. Only reset exits.
- Latency: the redirect is visible on pc one cycle after the ']' is presented. delay is high in that same cycle for exactly one cycle.
- Stack: push and pop never happen in the same cycle. The top-of-stack read is combinational from registered storage.
- fault implies halted.

Decomposition:
- beef_pkg holds:
  - opcodes as 9-bit ASCII: OP_NOP=9'h000, OP_OPEN=9'h05B, OP_CLOSE=9'h05D, OP_HALT=9'h100.
  - state enum seq_state_t {RUN, SEARCH, HALT}.
- Sub-module loop_stack (parameterised LIFO: STACK_DEPTH x PC_W) with ports push, pop, din, top, empty, full.

Test Plan:
- Program "+[-]" (NOPs for +/-), cell_zero=0 at ']' twice then 1 → pc sequence 0,1,2,3,2,3,2,3,4; delay pulses at the two jumps with delayed_op=1.
- "[[+]+]" at 0, then OP_HALT, with cell_zero=1 at pc0 → searching=1 for pcs 1..5, exits to pc=6 with delay=1 and delayed_op=0; depth peaks at 2; then halted=1 at pc6.
- ']' with an empty stack → fault=1 and halted=1 next cycle; pc frozen at the ']' address.
- 17 nested taken '[' with STACK_DEPTH=16 → fault on the 17th; the first 16 push without error.
- stall held for 3 cycles mid-SEARCH at depth 2 → pc and depth unchanged and delay=0 for those cycles; the search then completes normally.
- reset_n pulsed low asynchronously mid-search at pc=0x0040 → all outputs cleared immediately; pc=0 on the first edge after release.
